// File: rtl/mpe_pkg.sv
// mpe_pkg: shared types and configuration legality check for the MPE window sequencer.
// Contents: elem_t element type, state_t FSM encoding, cfg_legal() start-time config check.
// Build option: ZERO_PAD_EN drops the tile-bounds requirement from cfg_legal().
package mpe_pkg;

    localparam int ELEM_W = 16;

    typedef logic [ELEM_W-1:0] elem_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Without padding every tap of every window must land inside the tile,
    // so the farthest tap of the farthest window is checked against the edge.
    function automatic logic cfg_legal(
        input int kh,
        input int kw,
        input int stride,
        input int k_h,
        input int k_w,
        input int max_stride,
        input int in_h,
        input int in_w,
        input int out_h,
        input int out_w
    );
        logic ok;
        ok = kh >= 1 && kh <= k_h && kw >= 1 && kw <= k_w &&
             stride >= 1 && stride <= max_stride;
`ifndef ZERO_PAD_EN
        ok = ok && ((out_h - 1) * stride + kh - 1 <= in_h - 1) &&
                   ((out_w - 1) * stride + kw - 1 <= in_w - 1);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/mpe_window_mux.sv
// mpe_window_mux: combinational strided window select from a tile at tap (kh, kw).
// Ports: tile (IN_H x IN_W elements), kh/kw tap index, stride,
//        window (OUT_H x OUT_W elements), window[i][j] = tile[i*stride+kh][j*stride+kw].
// Build option: ZERO_PAD_EN reads any out-of-tile element as zero.
module mpe_window_mux #(
    parameter int BIN_LEN = 16,
    parameter int IN_H    = 8,
    parameter int IN_W    = 8,
    parameter int OUT_H   = 4,
    parameter int OUT_W   = 4,
    parameter int KHW     = 2,
    parameter int KWW     = 2
) (
    input  logic [IN_H-1:0][IN_W-1:0][BIN_LEN-1:0]   tile,
    input  logic [KHW-1:0]                           kh,
    input  logic [KWW-1:0]                           kw,
    input  logic [2:0]                               stride,
    output logic [OUT_H-1:0][OUT_W-1:0][BIN_LEN-1:0] window
);

    localparam int RW = $clog2(IN_H);
    localparam int CW = $clog2(IN_W);

`ifdef ZERO_PAD_EN
    int r, c;
`endif

    always_comb begin
        window = '0;
`ifdef ZERO_PAD_EN
        r = 0;
        c = 0;
`endif
        for (int i = 0; i < OUT_H; i++) begin
            for (int j = 0; j < OUT_W; j++) begin
`ifdef ZERO_PAD_EN
                r = i * int'(stride) + int'(kh);
                c = j * int'(stride) + int'(kw);
                window[i][j] = (r < IN_H && c < IN_W) ? tile[r[RW-1:0]][c[CW-1:0]] : '0;
`else
                window[i][j] = tile[RW'(i * int'(stride) + int'(kh))][CW'(j * int'(stride) + int'(kw))];
`endif
            end
        end
    end

endmodule

// File: rtl/mpe_window_sequencer.sv
// mpe_window_sequencer: latches a tile plus conv config, then streams one strided window per kernel tap.
// Ports: clk, rst (sync, active-high); start, in_vals, cfg_kh, cfg_kw, cfg_stride (job request);
//        out_vals, out_kh, out_kw, out_valid, out_ready, out_last (window stream);
//        busy, done, cfg_err (status).
// Build option: ZERO_PAD_EN allows windows that run off the tile (out-of-tile reads as zero).
module mpe_window_sequencer
    import mpe_pkg::*;
#(
    parameter int BIN_LEN    = 16,
    parameter int IN_H       = 8,
    parameter int IN_W       = 8,
    parameter int OUT_H      = 4,
    parameter int OUT_W      = 4,
    parameter int K_H        = 3,
    parameter int K_W        = 3,
    parameter int MAX_STRIDE = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [IN_H-1:0][IN_W-1:0][BIN_LEN-1:0]   in_vals,
    input  logic [$clog2(K_H+1)-1:0]                 cfg_kh,
    input  logic [$clog2(K_W+1)-1:0]                 cfg_kw,
    input  logic [2:0]                               cfg_stride,
    output logic [OUT_H-1:0][OUT_W-1:0][BIN_LEN-1:0] out_vals,
    output logic [$clog2(K_H)-1:0]                   out_kh,
    output logic [$clog2(K_W)-1:0]                   out_kw,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic                                     out_last,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     cfg_err
);

    state_t                                 state;
    logic [IN_H-1:0][IN_W-1:0][BIN_LEN-1:0] tile;
    logic [$clog2(K_H+1)-1:0]               kh_n;
    logic [$clog2(K_W+1)-1:0]               kw_n;
    logic [2:0]                             stride;
    logic                                   kh_end, kw_end, legal;

    assign legal  = cfg_legal(int'(cfg_kh), int'(cfg_kw), int'(cfg_stride), K_H, K_W,
                              MAX_STRIDE, IN_H, IN_W, OUT_H, OUT_W);
    assign kh_end = int'(out_kh) == int'(kh_n) - 1;
    assign kw_end = int'(out_kw) == int'(kw_n) - 1;
    // Gated by out_valid so stale counters in IDLE never flag a last beat.
    assign out_last = out_valid & kh_end & kw_end;
    assign busy     = state != IDLE;

    mpe_window_mux #(
        .BIN_LEN(BIN_LEN),
        .IN_H   (IN_H),
        .IN_W   (IN_W),
        .OUT_H  (OUT_H),
        .OUT_W  (OUT_W),
        .KHW    ($clog2(K_H)),
        .KWW    ($clog2(K_W))
    ) u_mux (
        .tile  (tile),
        .kh    (out_kh),
        .kw    (out_kw),
        .stride(stride),
        .window(out_vals)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tile      <= '0;
            kh_n      <= '0;
            kw_n      <= '0;
            stride    <= '0;
            out_kh    <= '0;
            out_kw    <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && legal) begin
                        tile      <= in_vals;
                        kh_n      <= cfg_kh;
                        kw_n      <= cfg_kw;
                        stride    <= cfg_stride;
                        out_kh    <= '0;
                        out_kw    <= '0;
                        out_valid <= 1'b1;
                        state     <= RUN;
                    end else if (start) begin
                        cfg_err <= 1'b1;
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        // Counters return to tap (0,0) after the final beat so the
                        // idle window stays inside the tile.
                        out_kw <= kw_end ? '0 : out_kw + 1'b1;
                        out_kh <= (kh_end && kw_end) ? '0 : kw_end ? out_kh + 1'b1 : out_kh;
                        if (kh_end && kw_end) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
